// File: rtl/op_serializer.sv
// Serializes one 40-bit opcode packet per frame onto an idle-high line: start bit, 40 data bits MSB first, IDLE_BITS stop bits.
// Define OP_SERIALIZER_PARITY_EN to insert an odd-parity bit between the data and stop bits.
module op_serializer #(
  parameter int CLK_DIV   = 8,
  parameter int IDLE_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [39:0] data,
  output logic        accept,
  output logic        busy,
  output logic        sdo,
  output logic        frame_done
);

  // state  | meaning
  // IDLE   | line high, waiting for a packet
  // START  | start bit (line low)
  // DATA   | shifting out shift_q[39]
  // PARITY | odd parity bit (parity build only)
  // STOP   | line high for IDLE_BITS bit periods
  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(CLK_DIV - 1);
  localparam logic [3:0]    GAP_INIT = 4'(IDLE_BITS - 1);

`ifdef OP_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q;
  logic [39:0]     shift_q;
  logic [TW-1:0]   timer_q;
  logic [5:0]      bit_cnt_q;
  logic [3:0]      gap_q;
  logic            sdo_q;
  logic            busy_q;
  logic            frame_done_q;
`ifdef OP_SERIALIZER_PARITY_EN
  logic            parity_q;
`endif

  assign accept     = (state_q == S_IDLE) && data_valid;
  assign busy       = busy_q;
  assign sdo        = sdo_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      sdo_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef OP_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_valid) begin
            shift_q <= data;
`ifdef OP_SERIALIZER_PARITY_EN
            parity_q <= ~^data;
`endif
            timer_q <= TMAX;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == '0) begin
            timer_q   <= TMAX;
            bit_cnt_q <= 6'd39;
            sdo_q     <= shift_q[39];
            state_q   <= S_DATA;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_DATA: begin
          if (timer_q == '0) begin
            timer_q <= TMAX;
            if (bit_cnt_q == '0) begin
`ifdef OP_SERIALIZER_PARITY_EN
              sdo_q   <= parity_q;
              state_q <= S_PARITY;
`else
              sdo_q   <= 1'b1;
              gap_q   <= GAP_INIT;
              state_q <= S_STOP;
`endif
            end else begin
              shift_q   <= {shift_q[38:0], 1'b0};
              sdo_q     <= shift_q[38];
              bit_cnt_q <= bit_cnt_q - 1'b1;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
`ifdef OP_SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (timer_q == '0) begin
            timer_q <= TMAX;
            sdo_q   <= 1'b1;
            gap_q   <= GAP_INIT;
            state_q <= S_STOP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (timer_q == '0) begin
            if (gap_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gap_q   <= gap_q - 1'b1;
              timer_q <= TMAX;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
            // frame_done is registered, so raise it one cycle ahead of the last stop cycle
            if (timer_q == TW'(1) && gap_q == '0) frame_done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_serializer.sv
// Self-checking bench for op_serializer: two instances (CLK_DIV=4/IDLE_BITS=2 and CLK_DIV=2/IDLE_BITS=1)
// compared every cycle against a frame-offset reference model, plus directed scenario checks.
module tb_op_serializer;
  localparam int CD_A = 4, IB_A = 2, CD_B = 2, IB_B = 1;
`ifdef OP_SERIALIZER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LEN_A = (41 + PB + IB_A) * CD_A;
  localparam int LEN_B = (41 + PB + IB_B) * CD_B;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dv_a = 1'b0, dv_b = 1'b0;
  logic [39:0] data_a = '0, data_b = '0;
  logic acc_a, busy_a, sdo_a, fd_a;
  logic acc_b, busy_b, sdo_b, fd_b;

  always #5 clk = ~clk;

  op_serializer #(.CLK_DIV(CD_A), .IDLE_BITS(IB_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_a), .data(data_a),
    .accept(acc_a), .busy(busy_a), .sdo(sdo_a), .frame_done(fd_a));

  op_serializer #(.CLK_DIV(CD_B), .IDLE_BITS(IB_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_b), .data(data_b),
    .accept(acc_b), .busy(busy_b), .sdo(sdo_b), .frame_done(fd_b));

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected line level at 1-based cycle offset 'off' into a frame of packet pkt.
  function automatic logic exp_bit(input logic [39:0] pkt, input int off, input int cd);
    int idx;
    idx = (off - 1) / cd;
    if (idx == 0) return 1'b0;
    if (idx <= 40) return pkt[40 - idx];
    if (PB == 1 && idx == 41) return ~^pkt;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc++;

  int off_a = 0, off_b = 0;
  logic [39:0] pkt_a, pkt_b;
  int acc_q_a[$], fd_q_a[$], acc_q_b[$], fd_q_b[$];

  always @(negedge clk) begin
    if (acc_a) acc_q_a.push_back(cyc);
    if (fd_a)  fd_q_a.push_back(cyc);
    if (!rst_n) begin
      off_a = 0;
      chk("a_rst_sdo", 64'(sdo_a), 64'd1);
      chk("a_rst_busy", 64'(busy_a), 64'd0);
      chk("a_rst_fd", 64'(fd_a), 64'd0);
    end else if (off_a == 0) begin
      chk("a_idle_acc", 64'(acc_a), 64'(dv_a));
      chk("a_idle_sdo", 64'(sdo_a), 64'd1);
      chk("a_idle_busy", 64'(busy_a), 64'd0);
      chk("a_idle_fd", 64'(fd_a), 64'd0);
      if (dv_a) begin pkt_a = data_a; off_a = 1; end
    end else begin
      chk("a_sdo", 64'(sdo_a), 64'(exp_bit(pkt_a, off_a, CD_A)));
      chk("a_busy", 64'(busy_a), 64'd1);
      chk("a_fd", 64'(fd_a), 64'(off_a == LEN_A));
      chk("a_acc_busy", 64'(acc_a), 64'd0);
      off_a = (off_a == LEN_A) ? 0 : off_a + 1;
    end
  end

  always @(negedge clk) begin
    if (acc_b) acc_q_b.push_back(cyc);
    if (fd_b)  fd_q_b.push_back(cyc);
    if (!rst_n) begin
      off_b = 0;
      chk("b_rst_sdo", 64'(sdo_b), 64'd1);
      chk("b_rst_busy", 64'(busy_b), 64'd0);
    end else if (off_b == 0) begin
      chk("b_idle_acc", 64'(acc_b), 64'(dv_b));
      chk("b_idle_sdo", 64'(sdo_b), 64'd1);
      chk("b_idle_fd", 64'(fd_b), 64'd0);
      if (dv_b) begin pkt_b = data_b; off_b = 1; end
    end else begin
      chk("b_sdo", 64'(sdo_b), 64'(exp_bit(pkt_b, off_b, CD_B)));
      chk("b_busy", 64'(busy_b), 64'd1);
      chk("b_fd", 64'(fd_b), 64'(off_b == LEN_B));
      chk("b_acc_busy", 64'(acc_b), 64'd0);
      off_b = (off_b == LEN_B) ? 0 : off_b + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q_a.delete(); fd_q_a.delete(); acc_q_b.delete(); fd_q_b.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_sdo", 64'(sdo_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_fd", 64'(fd_a), 64'd0);
    chk("rst_acc", 64'(acc_a), 64'd0);
    rst_n = 1'b1;

    // power-on packet on A, single-high-bit packet on B
    step();
    clear_q();
    data_a = 40'hc671000000; dv_a = 1'b1;
    data_b = 40'h0000000001; dv_b = 1'b1;
    step();
    dv_a = 1'b0; dv_b = 1'b0;
    data_a = {8'($urandom), 32'($urandom)};
    repeat (LEN_A + 5) step();
    chk("po_acc_cnt", 64'(acc_q_a.size()), 64'd1);
    chk("po_fd_cnt", 64'(fd_q_a.size()), 64'd1);
    if (acc_q_a.size() == 1 && fd_q_a.size() == 1)
      chk("po_len", 64'(fd_q_a[0] - acc_q_a[0]), 64'(LEN_A));
    chk("sweep_fd_cnt", 64'(fd_q_b.size()), 64'd1);
    if (acc_q_b.size() == 1 && fd_q_b.size() == 1)
      chk("sweep_len", 64'(fd_q_b[0] - acc_q_b[0]), 64'(LEN_B));

    // valid held high across two frames
    clear_q();
    data_a = 40'hc610001234; dv_a = 1'b1;
    repeat (LEN_A + 20) step();
    dv_a = 1'b0;
    repeat (LEN_A) step();
    chk("held_acc_cnt", 64'(acc_q_a.size()), 64'd2);
    if (acc_q_a.size() == 2)
      chk("held_spacing", 64'(acc_q_a[1] - acc_q_a[0]), 64'(LEN_A + 1));

    // mic packet presented and withdrawn while busy
    clear_q();
    data_a = {8'($urandom), 32'($urandom)}; dv_a = 1'b1;
    step();
    dv_a = 1'b0;
    repeat (50) step();
    data_a = 40'hc7deadbeef; dv_a = 1'b1;
    repeat (60) step();
    dv_a = 1'b0;
    repeat (LEN_A) step();
    chk("busy_acc_cnt", 64'(acc_q_a.size()), 64'd1);

    // reset during data bit 20
    clear_q();
    data_a = {8'($urandom), 32'($urandom)}; dv_a = 1'b1;
    step();
    dv_a = 1'b0;
    repeat (82) step();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_sdo", 64'(sdo_a), 64'd1);
    chk("mrst_busy", 64'(busy_a), 64'd0);
    repeat (3) step();
    #1 rst_n = 1'b1;
    step();
    chk("mrst_no_fd", 64'(fd_q_a.size()), 64'd0);
    data_a = {8'($urandom), 32'($urandom)}; dv_a = 1'b1;
    step();
    dv_a = 1'b0;
    repeat (LEN_A + 5) step();
    chk("mrst_new_fd", 64'(fd_q_a.size()), 64'd1);

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      dv_a = ($urandom_range(7) == 0);
      dv_b = ($urandom_range(5) == 0);
      data_a = {8'($urandom), 32'($urandom)};
      data_b = {8'($urandom), 32'($urandom)};
      step();
    end
    dv_a = 1'b0; dv_b = 1'b0;
    repeat (LEN_A + 5) step();
    chk("end_busy_a", 64'(busy_a), 64'd0);
    chk("end_busy_b", 64'(busy_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
